// File: rtl/calc_pkg.sv
// Shared definitions for the four-function calculator: key codes, FSM states
// and the default display range.
package calc_pkg;

    localparam logic [4:0] OP_AC  = 5'd10;
    localparam logic [4:0] OP_DIV = 5'd13;
    localparam logic [4:0] OP_MUL = 5'd14;
    localparam logic [4:0] OP_SUB = 5'd15;
    localparam logic [4:0] OP_ADD = 5'd16;
    localparam logic [4:0] OP_EQ  = 5'd17;

    localparam int MAX_MAG_DEFAULT = 99999;
    localparam int DIV_W_DEFAULT   = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GOT_A    = 3'd1,
        WAIT_B   = 3'd2,
        GOT_B    = 3'd3,
        EXEC     = 3'd4,
        DIV_BUSY = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } state_t;

    // True for the four arithmetic operator keys.
    function automatic logic is_arith_op(input logic [4:0] code);
        return (code == OP_ADD) || (code == OP_SUB) ||
               (code == OP_MUL) || (code == OP_DIV);
    endfunction

endpackage

// File: rtl/calc_div_seq.sv
// Unsigned restoring divider. The first iteration is folded into the start
// cycle so the final quotient and the done pulse appear W cycles after start.
module calc_div_seq
    import calc_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [W-1:0]  src_rem;
    logic [W-1:0]  src_quo;
    logic [W-1:0]  src_dvs;
    logic [W:0]    shifted;
    logic [W-1:0]  step_rem;
    logic [W-1:0]  step_quo;

    // One restoring step on either the fresh operands (start) or the running state.
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_quo  = start ? dividend : quo_q;
        src_dvs  = start ? divisor : dvs_q;
        shifted  = {src_rem, src_quo[W-1]};
        step_rem = shifted[W-1:0];
        step_quo = {src_quo[W-2:0], 1'b0};
        if (shifted >= {1'b0, src_dvs}) begin
            step_rem = shifted[W-1:0] - src_dvs;
            step_quo = {src_quo[W-2:0], 1'b1};
        end
    end

    // Iteration control: abort wins, start loads and steps once, busy keeps stepping.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            dvs_d  = divisor;
            cnt_d  = CW'(1);
            busy_d = (W > 1);
            done_d = (W == 1);
        end else if (busy_q) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator entry sequencer: operand/operator FSM, single-cycle add/sub/mul,
// sign handling around the sequential divider, and the display range check.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_MAG = MAX_MAG_DEFAULT,
    parameter int DIV_W   = DIV_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        operand_valid,
    input  logic [31:0] operand,
    input  logic        overflow_in,
    input  logic        operator_valid,
    input  logic [4:0]  operator,
    output logic [31:0] display_value,
    output logic        result_valid,
    output logic        error,
    output logic        busy,
    output logic [2:0]  state
);

    localparam logic signed [63:0] MAX_POS = 64'(MAX_MAG);
    localparam logic signed [63:0] MAX_NEG = -64'(MAX_MAG);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  op_q, op_d;
    logic [4:0]  next_op_q, next_op_d;
    logic        chain_q, chain_d;
    logic [31:0] result_q, result_d;
    logic        div_neg_q, div_neg_d;
    logic [31:0] display_q, display_d;
    logic        result_valid_q, result_valid_d;
    logic        error_q, error_d;
    logic        busy_q, busy_d;

    logic              ac;
    logic              key_arith;
    logic              key_eq;
    logic              num_ok;
    logic              num_bad;
    logic              div_start;
    logic              div_done;
    logic [DIV_W-1:0]  div_quo;
    logic [31:0]       a_mag;
    logic [31:0]       b_mag;
    logic [31:0]       quo_mag;
    logic [31:0]       quo_signed;
    logic              quo_err;
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] alu_r;
    logic              alu_err;
    logic              completing;
    logic [31:0]       fin_val;

    // Decode strobes: AC first, then any recognised operator drops a same-cycle operand.
    always_comb begin
        ac        = operator_valid && (operator == OP_AC);
        key_arith = operator_valid && is_arith_op(operator);
        key_eq    = operator_valid && (operator == OP_EQ);
        num_ok    = operand_valid && !key_arith && !key_eq && !ac && !overflow_in;
        num_bad   = operand_valid && !key_arith && !key_eq && !ac && overflow_in;
    end

    // Single-cycle ALU and range check, plus sign/magnitude handling for the divider.
    always_comb begin
        a_ext = 64'(signed'(a_q));
        b_ext = 64'(signed'(b_q));
        case (op_q)
            OP_SUB:  alu_r = a_ext - b_ext;
            OP_MUL:  alu_r = a_ext * b_ext;
            default: alu_r = a_ext + b_ext;
        endcase
        alu_err    = (alu_r > MAX_POS) || (alu_r < MAX_NEG);
        a_mag      = a_q[31] ? (32'd0 - a_q) : a_q;
        b_mag      = b_q[31] ? (32'd0 - b_q) : b_q;
        quo_mag    = 32'(div_quo);
        quo_err    = quo_mag > 32'(MAX_MAG);
        quo_signed = div_neg_q ? (32'd0 - quo_mag) : quo_mag;
    end

    // Next-state and register updates for the entry FSM.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        next_op_d      = next_op_q;
        chain_d        = chain_q;
        result_d       = result_q;
        div_neg_d      = div_neg_q;
        result_valid_d = 1'b0;
        div_start      = 1'b0;
        completing     = 1'b0;
        fin_val        = '0;
        if (ac) begin
            state_d   = IDLE;
            a_d       = '0;
            b_d       = '0;
            op_d      = '0;
            next_op_d = '0;
            chain_d   = 1'b0;
            result_d  = '0;
            div_neg_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (num_bad) begin
                        state_d = ERR;
                    end else if (num_ok) begin
                        a_d     = operand;
                        state_d = GOT_A;
                    end else if (key_arith) begin
                        a_d     = '0;
                        op_d    = operator;
                        state_d = WAIT_B;
                    end
                end
                GOT_A: begin
                    if (num_bad) begin
                        state_d = ERR;
                    end else if (num_ok) begin
                        a_d = operand;
                    end else if (key_arith) begin
                        op_d    = operator;
                        state_d = WAIT_B;
                    end else if (key_eq) begin
                        result_d = a_q;
                        state_d  = DONE;
                    end
                end
                WAIT_B: begin
                    if (num_bad) begin
                        state_d = ERR;
                    end else if (num_ok) begin
                        b_d     = operand;
                        state_d = GOT_B;
                    end else if (key_arith) begin
                        op_d = operator;
                    end
                end
                GOT_B: begin
                    if (num_bad) begin
                        state_d = ERR;
                    end else if (num_ok) begin
                        b_d = operand;
                    end else if (key_eq) begin
                        chain_d = 1'b0;
                        state_d = EXEC;
                    end else if (key_arith) begin
                        chain_d   = 1'b1;
                        next_op_d = operator;
                        state_d   = EXEC;
                    end
                end
                EXEC: begin
                    if (op_q == OP_DIV) begin
                        if (b_q == '0) begin
                            state_d = ERR;
                        end else begin
                            div_start = 1'b1;
                            div_neg_d = a_q[31] ^ b_q[31];
                            state_d   = DIV_BUSY;
                        end
                    end else if (alu_err) begin
                        state_d = ERR;
                    end else begin
                        completing = 1'b1;
                        fin_val    = alu_r[31:0];
                    end
                end
                DIV_BUSY: begin
                    if (div_done) begin
                        if (quo_err) begin
                            state_d = ERR;
                        end else begin
                            completing = 1'b1;
                            fin_val    = quo_signed;
                        end
                    end
                end
                DONE: begin
                    if (num_bad) begin
                        state_d = ERR;
                    end else if (num_ok) begin
                        a_d     = operand;
                        state_d = GOT_A;
                    end else if (key_arith) begin
                        a_d     = result_q;
                        op_d    = operator;
                        state_d = WAIT_B;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (completing) begin
                result_d       = fin_val;
                result_valid_d = 1'b1;
                if (chain_q) begin
                    a_d     = fin_val;
                    op_d    = next_op_q;
                    chain_d = 1'b0;
                    state_d = WAIT_B;
                end else begin
                    state_d = DONE;
                end
            end
        end
    end

    // Registered outputs derived from the state being entered.
    always_comb begin
        case (state_d)
            IDLE:          display_d = '0;
            GOT_A, WAIT_B: display_d = a_d;
            GOT_B:         display_d = b_d;
            DONE:          display_d = result_d;
            ERR:           display_d = '0;
            default:       display_d = display_q;
        endcase
        error_d = (state_d == ERR);
        busy_d  = (state_d == EXEC) || (state_d == DIV_BUSY);
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            next_op_q      <= '0;
            chain_q        <= 1'b0;
            result_q       <= '0;
            div_neg_q      <= 1'b0;
            display_q      <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            next_op_q      <= next_op_d;
            chain_q        <= chain_d;
            result_q       <= result_d;
            div_neg_q      <= div_neg_d;
            display_q      <= display_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
            busy_q         <= busy_d;
        end
    end

    calc_div_seq #(
        .W(DIV_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (ac),
        .dividend (DIV_W'(a_mag)),
        .divisor  (DIV_W'(b_mag)),
        .quotient (div_quo),
        .done     (div_done)
    );

    assign display_value = display_q;
    assign result_valid  = result_valid_q;
    assign error         = error_q;
    assign busy          = busy_q;
    assign state         = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer.
module tb_calc_sequencer;

    localparam logic [4:0] K_AC  = 5'd10;
    localparam logic [4:0] K_DIV = 5'd13;
    localparam logic [4:0] K_MUL = 5'd14;
    localparam logic [4:0] K_ADD = 5'd16;
    localparam logic [4:0] K_EQ  = 5'd17;

    localparam int S_IDLE     = 0;
    localparam int S_GOT_A    = 1;
    localparam int S_WAIT_B   = 2;
    localparam int S_GOT_B    = 3;
    localparam int S_EXEC     = 4;
    localparam int S_DIV_BUSY = 5;
    localparam int S_DONE     = 6;
    localparam int S_ERR      = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        operand_valid;
    logic [31:0] operand;
    logic        overflow_in;
    logic        operator_valid;
    logic [4:0]  operator;
    logic [31:0] display_value;
    logic        result_valid;
    logic        error;
    logic        busy;
    logic [2:0]  state;

    int compared   = 0;
    int mismatched = 0;

    calc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .operand_valid  (operand_valid),
        .operand        (operand),
        .overflow_in    (overflow_in),
        .operator_valid (operator_valid),
        .operator       (operator),
        .display_value  (display_value),
        .result_valid   (result_valid),
        .error          (error),
        .busy           (busy),
        .state          (state)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Backstop so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of strobes from a falling edge; return at the next falling edge.
    task automatic applyStimulus(input logic ov, input logic [31:0] val, input logic ovf,
                                 input logic kv, input logic [4:0] code);
        operand_valid  = ov;
        operand        = val;
        overflow_in    = ovf;
        operator_valid = kv;
        operator       = code;
        @(posedge clk);
        @(negedge clk);
        operand_valid  = 1'b0;
        operand        = '0;
        overflow_in    = 1'b0;
        operator_valid = 1'b0;
        operator       = '0;
    endtask

    task automatic num(input logic [31:0] v);
        applyStimulus(1'b1, v, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic key(input logic [4:0] c);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, c);
    endtask

    // Full divide sequence with latency measured from the '=' strobe.
    task automatic runDivide(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic signed [31:0] expected);
        int lat;
        num(a);
        key(K_DIV);
        num(b);
        key(K_EQ);
        checkOutput({tag, "_exec"}, 32'(state), S_EXEC);
        lat = 1;
        while (!result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, 34);
        checkOutput({tag, "_value"}, display_value, expected);
        checkOutput({tag, "_state"}, 32'(state), S_DONE);
        key(K_AC);
    endtask

    initial begin
        int pulses;
        rst            = 1'b0;
        operand_valid  = 1'b0;
        operand        = '0;
        overflow_in    = 1'b0;
        operator_valid = 1'b0;
        operator       = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 32'(state), S_IDLE);
        checkOutput("reset_display", display_value, 0);
        checkOutput("reset_rv", 32'(result_valid), 0);
        checkOutput("reset_error", 32'(error), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        rst = 1'b1;
        @(negedge clk);

        // 12 + 34 =
        num(32'd12);
        checkOutput("add_gota", 32'(state), S_GOT_A);
        checkOutput("add_disp_a", display_value, 12);
        key(K_ADD);
        checkOutput("add_waitb", 32'(state), S_WAIT_B);
        num(32'd34);
        checkOutput("add_gotb", 32'(state), S_GOT_B);
        checkOutput("add_disp_b", display_value, 34);
        key(K_EQ);
        checkOutput("add_exec", 32'(state), S_EXEC);
        checkOutput("add_busy", 32'(busy), 1);
        checkOutput("add_rv_early", 32'(result_valid), 0);
        @(negedge clk);
        checkOutput("add_rv", 32'(result_valid), 1);
        checkOutput("add_value", display_value, 46);
        checkOutput("add_done", 32'(state), S_DONE);
        @(negedge clk);
        checkOutput("add_rv_pulse", 32'(result_valid), 0);
        key(K_AC);
        checkOutput("ac_idle", 32'(state), S_IDLE);
        checkOutput("ac_disp", display_value, 0);

        // Divides
        runDivide("div_pos", 32'd100, 32'd7, 14);
        runDivide("div_neg", -32'sd100, 32'd7, -14);
        runDivide("div_zero_q", 32'd7, 32'd100, 0);

        // 2 + 3 * 4 =  (left to right)
        num(32'd2);
        key(K_ADD);
        num(32'd3);
        key(K_MUL);
        checkOutput("chain_exec", 32'(state), S_EXEC);
        @(negedge clk);
        checkOutput("chain_rv1", 32'(result_valid), 1);
        checkOutput("chain_val1", display_value, 5);
        checkOutput("chain_waitb", 32'(state), S_WAIT_B);
        num(32'd4);
        checkOutput("chain_disp_b", display_value, 4);
        key(K_EQ);
        @(negedge clk);
        checkOutput("chain_rv2", 32'(result_valid), 1);
        checkOutput("chain_val2", display_value, 20);
        checkOutput("chain_done", 32'(state), S_DONE);
        key(K_AC);

        // 5 / 0 =
        num(32'd5);
        key(K_DIV);
        num(32'd0);
        key(K_EQ);
        @(negedge clk);
        checkOutput("dz_state", 32'(state), S_ERR);
        checkOutput("dz_error", 32'(error), 1);
        checkOutput("dz_rv", 32'(result_valid), 0);
        checkOutput("dz_disp", display_value, 0);
        num(32'd3);
        checkOutput("dz_ignore_num", 32'(state), S_ERR);
        key(K_ADD);
        checkOutput("dz_ignore_key", 32'(state), S_ERR);
        checkOutput("dz_ignore_disp", display_value, 0);
        key(K_AC);
        checkOutput("dz_ac_state", 32'(state), S_IDLE);
        checkOutput("dz_ac_error", 32'(error), 0);
        checkOutput("dz_ac_disp", display_value, 0);

        // 999 * 999 = out of range
        num(32'd999);
        key(K_MUL);
        num(32'd999);
        key(K_EQ);
        @(negedge clk);
        checkOutput("rng_state", 32'(state), S_ERR);
        checkOutput("rng_error", 32'(error), 1);
        checkOutput("rng_rv", 32'(result_valid), 0);
        key(K_AC);
        checkOutput("rng_ac_state", 32'(state), S_IDLE);
        checkOutput("rng_ac_disp", display_value, 0);

        // Abort a divide on cycle 10 of DIV_BUSY
        num(32'd9);
        key(K_DIV);
        num(32'd3);
        key(K_EQ);
        @(negedge clk);
        checkOutput("abort_divbusy", 32'(state), S_DIV_BUSY);
        repeat (9) @(negedge clk);
        checkOutput("abort_still_busy", 32'(state), S_DIV_BUSY);
        key(K_AC);
        checkOutput("abort_idle", 32'(state), S_IDLE);
        checkOutput("abort_rv", 32'(result_valid), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        checkOutput("abort_no_pulse", pulses, 0);
        num(32'd1);
        key(K_ADD);
        num(32'd1);
        key(K_EQ);
        @(negedge clk);
        checkOutput("after_abort_rv", 32'(result_valid), 1);
        checkOutput("after_abort_val", display_value, 2);
        key(K_AC);

        // Malformed operand in GOT_B
        num(32'd1);
        key(K_ADD);
        num(32'd2);
        applyStimulus(1'b1, 32'd5, 1'b1, 1'b0, 5'd0);
        checkOutput("ovf_state", 32'(state), S_ERR);
        checkOutput("ovf_error", 32'(error), 1);
        key(K_AC);

        // Operand and '+' together in GOT_A: operand dropped
        num(32'd5);
        applyStimulus(1'b1, 32'd8, 1'b0, 1'b1, K_ADD);
        checkOutput("both_state", 32'(state), S_WAIT_B);
        checkOutput("both_disp", display_value, 5);
        num(32'd3);
        key(K_EQ);
        @(negedge clk);
        checkOutput("both_rv", 32'(result_valid), 1);
        checkOutput("both_val", display_value, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Operation sequencer for the four-function calculator. Consumes the signed binary operands and 5-bit operator codes produced by the keypad decoder and runs the entry state machine: operand A, operator, operand B, then `=` or a chained operator. Drives an internal ALU with single-cycle add/sub/mul and a multi-cycle sequential divider. Presents the value to display, a result strobe and an error flag to the display/segment driver.

## Interface
- `MAX_MAG`, 99999: largest displayable result magnitude; anything larger is an error.
- `DIV_W`, 32: divider iteration count (operand magnitude width).
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `operand_valid`  in  1: one-cycle strobe; `operand` holds a new entered number.
- `operand`  in  32: two's-complement operand from the keypad decoder.
- `overflow_in`  in  1: qualified by `operand_valid`; the entered number was malformed.
- `operator_valid`  in  1: one-cycle strobe; `operator` holds a key code.
- `operator`  in  5: 16 `+`, 15 `-`, 14 `*`, 13 `/`, 17 `=`, 10 AC; other codes are ignored.
- `display_value`  out  32: signed value to show.
- `result_valid`  out  1: one-cycle pulse when a computation completes without error.
- `error`  out  1: level; high in ERR.
- `busy`  out  1: high in EXEC and DIV_BUSY.
- `state`  out  3: current state encoding, for debug and display.

## Operation
- States: IDLE, GOT_A, WAIT_B, GOT_B, EXEC, DIV_BUSY, DONE, ERR.
- Registers: A, B, pending op, result.
- Strobe priority:
  - AC beats everything.
  - Any other operator beats an operand strobe in the same cycle; the operand is dropped.
- AC in any state, including EXEC and DIV_BUSY: clear A, B, op and result; go to IDLE next cycle. An aborted divide produces no `result_valid`.
- Operand strobe with `overflow_in` = 1 → ERR, from any state except EXEC, DIV_BUSY and ERR.
- IDLE:
  - operand → A, then GOT_A.
  - `+ - * /` → A=0, then WAIT_B.
  - `=` ignored.
- GOT_A:
  - operand replaces A.
  - `+ - * /` latches op, then WAIT_B.
  - `=` → result=A, then DONE.
- WAIT_B:
  - operand → B, then GOT_B.
  - operator replaces op.
  - `=` ignored.
- GOT_B:
  - operand replaces B.
  - `=` → EXEC; on completion go to DONE.
  - `+ - * /` → EXEC with the old op. On completion A=result, op=new op, then WAIT_B. Evaluation is strictly left-to-right.
- DONE:
  - operand → new A, then GOT_A.
  - `+ - * /` → A=result, then WAIT_B.
  - `=` ignored.
- EXEC / DIV_BUSY: all strobes except AC are ignored.
- ERR: only AC exits.
- Arithmetic:
  - add/sub are 33-bit signed.
  - mul is a 64-bit signed product.
  - Error if |result| > `MAX_MAG`.
  - Divide uses sign-magnitude around an unsigned restoring divider. The quotient truncates toward zero and the remainder is discarded.
  - B=0 with `/` → ERR without starting the divider.
- `display_value` by state:
  - IDLE: 0.
  - GOT_A, WAIT_B: A.
  - GOT_B: B.
  - DONE, and WAIT_B after a chained op: result.
  - ERR: 0.
  - EXEC, DIV_BUSY: holds the previous value.
- `result_valid` pulses on the completion cycle for both `=` and chained ops. It never pulses on entry to ERR.

## Timing
- Reset values: state=IDLE, `display_value`=0, `result_valid`=0, `error`=0, `busy`=0, all internal registers 0.
- All outputs are registered.
- Strobe at cycle n: the new state and display are visible at n+1.
- add/sub/mul: EXEC in n+1, completion (DONE or WAIT_B) with `result_valid` in n+2.
- Divide:
  - EXEC in n+1 issues a one-cycle `start`.
  - DIV_BUSY covers n+2 … n+1+`DIV_W`.
  - Completion with `result_valid` at n+2+`DIV_W` (n+34 by default).
- Errors detected at EXEC (div-by-zero or range) → ERR at n+2 with `error`=1.
- AC strobe at cycle m → IDLE at m+1, regardless of the divider's state.

## Structure
- Shared package `calc_pkg`:
  - operator code constants (OP_ADD=16, OP_SUB=15, OP_MUL=14, OP_DIV=13, OP_EQ=17, OP_AC=10);
  - state enum;
  - `MAX_MAG` default.
- Sub-module `calc_div_seq`:
  - unsigned restoring divider, `DIV_W` iterations;
  - ports: `clk`, `rst`, `start`, `abort`, dividend, divisor, quotient, `done`;
  - `abort` is driven by AC.
- The sequencer owns the FSM, the sign handling and the range check.

## Test plan
- Strobes 12, `+`, 34, `=` → `result_valid` two cycles after `=`, `display_value`=46, state DONE.
- Strobes 100, `/`, 7, `=` → `result_valid` exactly 34 cycles after `=`, value 14. Repeat with -100 → -14. Repeat with 7, `/`, 100 → 0.
- Strobes 2, `+`, 3, `*`, 4, `=` → first `result_valid` shows 5 and state WAIT_B; second `result_valid` shows 20.
- Strobes 5, `/`, 0, `=` → `error`=1 with no `result_valid`. Strobes 999, `*`, 999, `=` → `error`=1. In both cases a later AC gives IDLE and `display_value`=0; other strobes in ERR are ignored.
- Strobes 9, `/`, 3, `=`, then AC at cycle 10 of DIV_BUSY → IDLE next cycle, no `result_valid`. A new 1, `+`, 1, `=` then gives 2.
- Operand strobe with `overflow_in`=1 in GOT_B → ERR next cycle. Operand and `+` strobed together in GOT_A → op latched, A unchanged, state WAIT_B.
